decoder_nto2n_hs: RTL and testbench
===================================

DECODER_NTO2N_HS -- requirements
Module: decoder_nto2n_hs

Interface
REQ-001 The block SHALL have parameter IN_W, default 2, meaning the binary code width (1..8).
REQ-002 The block SHALL have parameter OUT_W, default 4, meaning the one-hot output width (2..2**IN_W).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: decode enable, sampled together with din on acceptance.
REQ-006 The block SHALL have port din, input, IN_W bits: binary code to decode.
REQ-007 The block SHALL have port in_valid, input, 1 bit: din/en are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept din.
REQ-009 The block SHALL have port dout, output, OUT_W bits: registered one-hot result.
REQ-010 The block SHALL have port out_valid, output, 1 bit: dout/err hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port err, output, 1 bit: the held result came from an out-of-range code (din >= OUT_W).
REQ-013 The block SHALL have port sweep_start, input, 1 bit: request a self-test sweep (see Configuration).
REQ-014 The block SHALL have port sweep_busy, output, 1 bit: a sweep is in progress.

Function
REQ-015 The block SHALL assert in_ready = (!out_valid || out_ready) && state==IDLE, combinationally.
REQ-016 The block SHALL accept an input on a rising edge where in_valid && in_ready.
REQ-017 On acceptance, the block SHALL set dout[k]=1 only for k==din when en=1 and din<OUT_W, with all other bits 0.
REQ-018 On acceptance with en=0, the block SHALL set dout to all-zero and err to 0, and SHALL still set out_valid=1.
REQ-019 On acceptance with en=1 and din>=OUT_W, the block SHALL set dout to all-zero and err=1.
REQ-020 The latency from acceptance to out_valid=1 SHALL be exactly one cycle, with a sustained throughput of one result per cycle when out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, dout, err and out_valid SHALL hold stable.
REQ-022 When out_valid && out_ready and no new acceptance occurs on the same edge, out_valid SHALL clear; dout and err keep their last values.
REQ-023 A simultaneous output transfer and new acceptance on the same edge SHALL load the new result with out_valid staying 1.
REQ-024 The state machine SHALL have the states IDLE and SWEEP; in IDLE, normal decode is active.

Reset
REQ-025 With rst_n=0, the block SHALL immediately force dout=0, err=0, out_valid=0, sweep_busy=0, state=IDLE and the sweep counter to 0, regardless of clk.
REQ-026 A reset asserted mid-sweep or while a result is held SHALL discard that activity; after rst_n rises, the first edge SHALL be able to accept input.

Configuration
REQ-027 With macro DECODER_SWEEP_EN defined, sweep_start=1 in IDLE while in_ready=1 SHALL move the state machine to SWEEP and set sweep_busy=1.
REQ-028 In SWEEP, the block SHALL emit the codes 0..OUT_W-1 in order as one-hot results (err=0), each through the out_valid/out_ready handshake; in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-029 With DECODER_SWEEP_EN defined, the edge that loads code OUT_W-1 SHALL return the block to IDLE and clear sweep_busy; sweep_start in SWEEP SHALL be ignored.
REQ-030 Without DECODER_SWEEP_EN, sweep_start SHALL be ignored, sweep_busy SHALL be tied 0, state SHALL remain IDLE, and no sweep counter SHALL be built.

Verification
REQ-031 IN_W=2, OUT_W=4, out_ready=1, en=1, in_valid=1 with din=0,1,2,3 on consecutive cycles -> dout = 0001, 0010, 0100, 1000 on the next cycles, out_valid continuously 1.
REQ-032 IN_W=3, OUT_W=6, din=6 with en=1 accepted -> dout=000000, err=1, out_valid=1; then din=5 -> dout=100000, err=0.
REQ-033 din=2 with en=0 accepted -> dout=0000, err=0, out_valid=1.
REQ-034 Backpressure: din=1 is accepted, then out_ready=0 for 3 cycles -> dout stays 0010, in_ready=0 while held; out_ready=1 together with din=3 -> dout=1000 the next cycle.
REQ-035 DECODER_SWEEP_EN, OUT_W=4: sweep_start pulse, out_ready=1 -> dout 0001, 0010, 0100, 1000 on consecutive cycles, sweep_busy=1 throughout, then 0, in_ready=1; in_valid during the sweep is not consumed.
REQ-036 Drop rst_n during the second sweep result -> dout=0, out_valid=0, sweep_busy=0 asynchronously; after release, din=3 is decoded normally.

Source files
------------

// File: rtl/decoder_nto2n_hs.sv
// decoder_nto2n_hs: binary-to-one-hot decoder, one registered stage, valid/ready on both sides.
// Optional self-test sweep of all codes is built only when DECODER_SWEEP_EN is defined.
module decoder_nto2n_hs #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  input  logic             sweep_start,
  output logic             sweep_busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [OUT_W-1:0] dout_q, dout_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [0:0]       state;
  logic             load_ok;
  logic             accept;
  logic             sweep_load;
  logic [OUT_W-1:0] sweep_onehot;
  logic [OUT_W-1:0] dec_onehot;
  logic             dec_oor;

  // The output register can take a new result when empty or being drained this edge.
  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = load_ok && (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_oor = en && ({1'b0, din} >= (IN_W+1)'(OUT_W));
    for (int k = 0; k < OUT_W; k++) begin
      dec_onehot[k] = en && ({1'b0, din} == (IN_W+1)'(k));
    end
  end

`ifdef DECODER_SWEEP_EN
  localparam int CW = $clog2(OUT_W);

  logic [0:0]    state_q, state_d;
  logic          sweep_busy_q, sweep_busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int k = 0; k < OUT_W; k++) begin
      sweep_onehot[k] = (cnt_q == CW'(k));
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_busy_d = sweep_busy_q;
    cnt_d        = cnt_q;
    sweep_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sweep_start && in_ready) begin
          state_d      = SWEEP;
          sweep_busy_d = 1'b1;
          cnt_d        = '0;
        end
      end
      SWEEP: begin
        if (load_ok) begin
          sweep_load = 1'b1;
          if (cnt_q == CW'(OUT_W-1)) begin
            state_d      = IDLE;
            sweep_busy_d = 1'b0;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sweep_busy_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sweep_busy_q <= sweep_busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign state      = state_q;
  assign sweep_busy = sweep_busy_q;
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign state              = IDLE;
  assign sweep_load         = 1'b0;
  assign sweep_onehot       = '0;
  assign sweep_busy         = 1'b0;
`endif

  always_comb begin
    dout_d      = dout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      dout_d      = dec_onehot;
      err_d       = dec_oor;
      out_valid_d = 1'b1;
    end else if (sweep_load) begin
      dout_d      = sweep_onehot;
      err_d       = 1'b0;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_decoder_nto2n_hs.sv
// Bench for decoder_nto2n_hs: a 2->4 and a 3->6 instance, scoreboard queues checked on output transfers.
module tb_decoder_nto2n_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       en = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sweep_start = 1'b0;
  logic [1:0] din = '0;
  logic       in_ready, out_valid, err, sweep_busy;
  logic [3:0] dout;

  logic       en6 = 1'b0, iv6 = 1'b0, or6 = 1'b1, ss6 = 1'b0;
  logic [2:0] din6 = '0;
  logic       ir6, ov6, err6, sb6;
  logic [5:0] dout6;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [3:0] d; logic e; } exp4_t;
  typedef struct packed { logic [5:0] d; logic e; } exp6_t;
  exp4_t q4[$];
  exp6_t q6[$];

  decoder_nto2n_hs #(.IN_W(2), .OUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy)
  );

  decoder_nto2n_hs #(.IN_W(3), .OUT_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en6), .din(din6), .in_valid(iv6), .in_ready(ir6),
    .dout(dout6), .out_valid(ov6), .out_ready(or6), .err(err6),
    .sweep_start(ss6), .sweep_busy(sb6)
  );

  // Scoreboards: each output transfer (valid && ready mid-cycle) pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp4_t x;
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL sb4_unexpected got dout=%b err=%b, expected no output", dout, err);
      end else begin
        x = q4.pop_front();
        if ({dout, err} !== x) begin
          failures++;
          $display("FAIL sb4_result got dout=%b err=%b, expected dout=%b err=%b", dout, err, x.d, x.e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov6 === 1'b1 && or6 === 1'b1) begin
      exp6_t y;
      checks++;
      if (q6.size() == 0) begin
        failures++;
        $display("FAIL sb6_unexpected got dout=%b err=%b, expected no output", dout6, err6);
      end else begin
        y = q6.pop_front();
        if ({dout6, err6} !== y) begin
          failures++;
          $display("FAIL sb6_result got dout=%b err=%b, expected dout=%b err=%b", dout6, err6, y.d, y.e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({dout, err, out_valid, sweep_busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%b err=%b ov=%b busy=%b, expected all 0", dout, err, out_valid, sweep_busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b, expected 1", in_ready);
    end
    checks++;
    if ({dout6, err6, ov6} !== 8'b0) begin
      failures++;
      $display("FAIL reset_dut6 got dout=%b err=%b ov=%b, expected all 0", dout6, err6, ov6);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1; en = 1'b1; in_valid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      din = 2'(d);
      q4.push_back(exp4_t'({4'(1 << d), 1'b0}));
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 4'(1 << d)) begin
        failures++;
        $display("FAIL stream_%0d got ov=%b dout=%b, expected ov=1 dout=%b", d, out_valid, dout, 4'(1 << d));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'b1000) begin
      failures++;
      $display("FAIL stream_drain got ov=%b dout=%b, expected ov=0 dout=1000", out_valid, dout);
    end
  endtask

  task automatic test_disabled();
    en = 1'b0; din = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    q4.push_back(exp4_t'({4'b0000, 1'b0}));
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dout !== 4'b0000 || err !== 1'b0) begin
      failures++;
      $display("FAIL disabled got ov=%b dout=%b err=%b, expected ov=1 dout=0000 err=0", out_valid, dout, err);
    end
    tick();
  endtask

  task automatic test_range();
    en6 = 1'b1; iv6 = 1'b1; din6 = 3'd6;
    q6.push_back(exp6_t'({6'b000000, 1'b1}));
    tick();
    checks++;
    if (ov6 !== 1'b1 || dout6 !== 6'b000000 || err6 !== 1'b1) begin
      failures++;
      $display("FAIL range_oor got ov=%b dout=%b err=%b, expected ov=1 dout=000000 err=1", ov6, dout6, err6);
    end
    din6 = 3'd5;
    q6.push_back(exp6_t'({6'b100000, 1'b0}));
    tick();
    checks++;
    if (ov6 !== 1'b1 || dout6 !== 6'b100000 || err6 !== 1'b0) begin
      failures++;
      $display("FAIL range_top got ov=%b dout=%b err=%b, expected ov=1 dout=100000 err=0", ov6, dout6, err6);
    end
    iv6 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; en = 1'b1; in_valid = 1'b1; din = 2'd1;
    q4.push_back(exp4_t'({4'b0010, 1'b0}));
    tick();
    din = 2'd2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready_%0d got %b, expected 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 4'b0010) begin
        failures++;
        $display("FAIL bp_hold_%0d got ov=%b dout=%b, expected ov=1 dout=0010", i, out_valid, dout);
      end
    end
    out_ready = 1'b1; din = 2'd3;
    q4.push_back(exp4_t'({4'b1000, 1'b0}));
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dout !== 4'b1000) begin
      failures++;
      $display("FAIL bp_reload got ov=%b dout=%b, expected ov=1 dout=1000", out_valid, dout);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'b1000) begin
      failures++;
      $display("FAIL bp_drain got ov=%b dout=%b, expected ov=0 dout=1000", out_valid, dout);
    end
  endtask

`ifdef DECODER_SWEEP_EN
  task automatic test_sweep();
    out_ready = 1'b1; in_valid = 1'b0; en = 1'b1; din = 2'd2; sweep_start = 1'b1;
    for (int d = 0; d < 4; d++) q4.push_back(exp4_t'({4'(1 << d), 1'b0}));
    tick();
    sweep_start = 1'b0; in_valid = 1'b1;
    checks++;
    if (sweep_busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_enter got busy=%b ir=%b ov=%b, expected busy=1 ir=0 ov=0", sweep_busy, in_ready, out_valid);
    end
    for (int d = 0; d < 4; d++) begin
      sweep_start = (d == 1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 4'(1 << d) || sweep_busy !== (d < 3)) begin
        failures++;
        $display("FAIL sweep_%0d got ov=%b dout=%b busy=%b, expected ov=1 dout=%b busy=%b",
                 d, out_valid, dout, sweep_busy, 4'(1 << d), (d < 3));
      end
    end
    in_valid = 1'b0; sweep_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL sweep_exit_ready got %b, expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sweep_busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_done got ov=%b busy=%b, expected ov=0 busy=0", out_valid, sweep_busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; sweep_start = 1'b1;
    for (int d = 0; d < 4; d++) q4.push_back(exp4_t'({4'(1 << d), 1'b0}));
    tick();
    sweep_start = 1'b0;
    tick();
    tick();
    checks++;
    if (dout !== 4'b0010 || sweep_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got dout=%b busy=%b, expected dout=0010 busy=1", dout, sweep_busy);
    end
`else
  task automatic test_sweep();
    out_ready = 1'b1; in_valid = 1'b0; sweep_start = 1'b1;
    tick();
    tick();
    sweep_start = 1'b0;
    checks++;
    if (sweep_busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL sweep_ignored got busy=%b ov=%b ir=%b, expected busy=0 ov=0 ir=1", sweep_busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; en = 1'b1; din = 2'd1; in_valid = 1'b1;
    q4.push_back(exp4_t'({4'b0010, 1'b0}));
    tick();
    in_valid = 1'b0;
    checks++;
    if (dout !== 4'b0010 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got dout=%b ov=%b, expected dout=0010 ov=1", dout, out_valid);
    end
`endif
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 4'b0000 || out_valid !== 1'b0 || sweep_busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got dout=%b ov=%b busy=%b, expected all 0", dout, out_valid, sweep_busy);
    end
    q4.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1; en = 1'b1; din = 2'd3; in_valid = 1'b1;
    q4.push_back(exp4_t'({4'b1000, 1'b0}));
    tick();
    in_valid = 1'b0;
    checks++;
    if (dout !== 4'b1000 || out_valid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after got dout=%b ov=%b err=%b, expected dout=1000 ov=1 err=0", dout, out_valid, err);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_disabled();
    test_range();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    tick();
    checks++;
    if (q4.size() != 0 || q6.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got q4=%0d q6=%0d pending, expected 0", q4.size(), q6.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
